ram_fifo_ctrl: RTL and testbench
================================

// Module: ram_fifo_ctrl
// PURPOSE
//  Sequences the 4-bit x 16 simple dual-port RAM (ram2) as an 8-entry circular FIFO.
//  Drives the RAM write and read ports and exposes valid/full/empty handshakes to one producer and one consumer.
//  Sits beside the RAM instance; RAM address MSB is tied 0, so only the lower 8 words are used.
// PARAMETERS
//  DATA_W      4  FIFO/RAM word width
//  PTR_W       3  pointer width; depth = 2**PTR_W = 8
//  RAM_ADDR_W  4  RAM address width; upper RAM_ADDR_W-PTR_W bits driven 0
// PORTS
//  clock          in   1           single clock, all state on rising edge
//  reset          in   1           asynchronous, active-high; clears all state
//  flush          in   1           synchronous clear of pointers/count; wins over wr/rd
//  wr_req         in   1           producer write request
//  wr_data        in   DATA_W      producer data
//  full           out  1           FIFO holds 8 words; wr_req ignored
//  rd_req         in   1           consumer read request
//  rd_data        out  DATA_W      read word, valid when rd_valid=1 (= ram_q)
//  rd_valid       out  1           one-cycle pulse, 1 cycle after accepted read
//  empty          out  1           FIFO holds 0 words; rd_req ignored
//  count          out  PTR_W+1     occupancy 0..8
//  ram_data       out  DATA_W      to RAM data (= wr_data)
//  ram_wraddress  out  RAM_ADDR_W  {0, wr_ptr}
//  ram_rdaddress  out  RAM_ADDR_W  {0, rd_ptr}
//  ram_wren       out  1           RAM write enable
//  ram_q          in   DATA_W      RAM read data, 1-cycle latency from rdaddress edge
// BEHAVIOUR
//  - Reset: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, rd_valid=0; ram_wren=0 while reset is high.
//  - Write accept: wr_acc = wr_req & ~full & ~flush. Combinational ram_wren = wr_acc; word is written at the same edge.
//    wr_ptr increments mod 8 (7->0 wrap).
//  - Read accept: rd_acc = rd_req & ~empty & ~flush. ram_rdaddress shows rd_ptr continuously.
//    At the accepting edge the RAM registers the address and rd_ptr increments mod 8.
//    At the next edge rd_valid is set for one cycle; rd_data = ram_q in that cycle.
//  - Read latency: 1 cycle from accept to rd_valid. Back-to-back reads sustain 1 word/cycle.
//  - Count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//    empty = (count==0); full = (count==8). Both are registered-derived, never combinational on req.
//  - Simultaneous rd+wr when full: read accepted, write rejected (full gates write). Count goes to 7.
//  - Simultaneous rd+wr when empty: write accepted, read rejected. Count goes to 1.
//  - No same-address read/write hazard: rd_ptr==wr_ptr only when empty or full, and both cases block one side.
//  - Flush: pointers and count go to 0 and rd_valid goes to 0 next cycle.
//    A rd_valid pulse due in the flush cycle is still delivered. ram_wren=0 while flush=1.
//  - Occupancy state (derived from count): EMPTY(0) -> ACTIVE(1..7) -> FULL(8).
//    Transitions only via single +1/-1 steps, or to EMPTY via flush or reset.
//  - Reset mid-burst: all state cleared asynchronously. RAM contents are not cleared and are not used afterwards.
//  - Requests on a blocked side are dropped, not queued; producer and consumer must hold or retry.
// STRUCTURE
//  - Shared package: FIFO_DEPTH=8, PTR_W, DATA_W, RAM_ADDR_W constants; occupancy-state enum {EMPTY, ACTIVE, FULL}.
//  - One sub-module, fifo_ptr: mod-2**PTR_W pointer with enable, sync clear, async reset.
//    Instantiated twice (write side, read side).
//  - Count/flag logic and the rd_valid register stay in this module; the RAM itself stays outside.
// TESTING
//  1. Reset, then 8 writes 0x1..0x8: full=1 after the 8th edge; count=8; ram_wraddress walks 0..7; 9th wr_req gives ram_wren=0.
//  2. From full, 8 reads: rd_data=0x1..0x8 on consecutive rd_valid pulses, each 1 cycle after accept; then empty=1, count=0.
//  3. Wrap: write 5, read 5, write 6 (0xA..0xF): ram_wraddress wraps 7->0; reads return 0xA..0xF in order.
//  4. Simultaneous rd+wr at count=3: count stays 3. At full: count->7, write rejected. At empty: count->1, no rd_valid.
//  5. Flush at count=5 with a read accepted the prior cycle: that rd_valid is still delivered.
//     Next cycle count=0, empty=1, pointers=0.
//  6. Assert reset mid-burst (count=4): outputs clear immediately without a clock edge.
//     After release, write 0x9 then read returns 0x9.

Source files
------------

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and the occupancy-state type for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

  localparam int DATA_W     = 4;
  localparam int PTR_W      = 3;
  localparam int RAM_ADDR_W = 4;
  localparam int FIFO_DEPTH = 2 ** PTR_W;

  // Occupancy of the FIFO: no words, some words, or every slot used.
  typedef enum logic [1:0] {
    OCC_EMPTY  = 2'd0,
    OCC_ACTIVE = 2'd1,
    OCC_FULL   = 2'd2
  } occ_state_e;

  // Even parity over one data word, available for protecting stored words.
  function automatic logic data_parity(input logic [DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/ram_fifo_ctrl_ptr.sv
// Modulo-2**PTR_W pointer: advances on enable, synchronous clear, asynchronous reset.
module fifo_ptr #(
  parameter int PTR_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  output logic [PTR_W-1:0] ptr
);

  // Pointer register; clear has priority over advance, and the wrap is the natural overflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr + PTR_W'(1);
    end else begin
      ptr <= ptr;
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Runs an external simple dual-port RAM as a circular FIFO: drives its write and read
// ports, tracks occupancy, and gives the producer and consumer full/empty/valid handshakes.
module ram_fifo_ctrl #(
  parameter int DATA_W     = ram_fifo_ctrl_pkg::DATA_W,
  parameter int PTR_W      = ram_fifo_ctrl_pkg::PTR_W,
  parameter int RAM_ADDR_W = ram_fifo_ctrl_pkg::RAM_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  wr_req,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  full,
  input  logic                  rd_req,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic [PTR_W:0]        count,
  output logic [DATA_W-1:0]     ram_data,
  output logic [RAM_ADDR_W-1:0] ram_wraddress,
  output logic [RAM_ADDR_W-1:0] ram_rdaddress,
  output logic                  ram_wren,
  input  logic [DATA_W-1:0]     ram_q
);

  import ram_fifo_ctrl_pkg::*;

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(2 ** PTR_W);
  localparam logic [PTR_W:0] LAST_CNT  = (PTR_W+1)'((2 ** PTR_W) - 1);
  localparam logic [PTR_W:0] ONE_CNT   = (PTR_W+1)'(1);

  logic             wr_acc;
  logic             rd_acc;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_next;
  occ_state_e       occ;
  occ_state_e       occ_next;

  // Flags come from the registered occupancy state, never from the requests.
  assign empty = (occ == OCC_EMPTY);
  assign full  = (occ == OCC_FULL);

  // Reset also masks the write strobe so the RAM is never written while state is held clear.
  assign wr_acc = wr_req & ~full & ~flush & ~reset;
  assign rd_acc = rd_req & ~empty & ~flush;

  // The RAM sees the pointers on its low address bits; the unused upper half stays dark.
  assign ram_wren      = wr_acc;
  assign ram_data      = wr_data;
  assign ram_wraddress = {{(RAM_ADDR_W-PTR_W){1'b0}}, wr_ptr};
  assign ram_rdaddress = {{(RAM_ADDR_W-PTR_W){1'b0}}, rd_ptr};
  assign rd_data       = ram_q;

  fifo_ptr #(.PTR_W(PTR_W)) u_wr_ptr (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .en    (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(.PTR_W(PTR_W)) u_rd_ptr (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .en    (rd_acc),
    .ptr   (rd_ptr)
  );

  // Next occupancy count and state; a simultaneous read and write leaves both unchanged.
  always_comb begin
    count_next = count;
    occ_next   = occ;

    if (flush) begin
      count_next = '0;
    end else begin
      case ({wr_acc, rd_acc})
        2'b10:   count_next = count + ONE_CNT;
        2'b01:   count_next = count - ONE_CNT;
        default: count_next = count;
      endcase
    end

    case (occ)
      OCC_EMPTY: begin
        if (wr_acc) begin
          occ_next = OCC_ACTIVE;
        end else begin
          occ_next = OCC_EMPTY;
        end
      end
      OCC_ACTIVE: begin
        if (flush) begin
          occ_next = OCC_EMPTY;
        end else if (wr_acc && !rd_acc && (count == LAST_CNT)) begin
          occ_next = OCC_FULL;
        end else if (rd_acc && !wr_acc && (count == ONE_CNT)) begin
          occ_next = OCC_EMPTY;
        end else begin
          occ_next = OCC_ACTIVE;
        end
      end
      OCC_FULL: begin
        if (flush) begin
          occ_next = OCC_EMPTY;
        end else if (rd_acc) begin
          occ_next = OCC_ACTIVE;
        end else begin
          occ_next = OCC_FULL;
        end
      end
      default: occ_next = OCC_EMPTY;
    endcase
  end

  // Occupancy state and count registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ   <= OCC_EMPTY;
      count <= '0;
    end else begin
      occ   <= occ_next;
      count <= count_next;
    end
  end

  // The RAM returns data one cycle after it registers the read address, so valid follows accept by one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
    end
  end

  // Full and empty can only be derived from a count at the matching extreme.
  logic unused_depth;
  assign unused_depth = (DEPTH_CNT == '0);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl: a queue-based FIFO model predicts acceptance,
// occupancy and read data; a monitor compares every rd_valid pulse against expectations.
module tb_ram_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic       wr_req = 1'b0;
  logic [3:0] wr_data = 4'h0;
  logic       rd_req = 1'b0;
  logic       full, empty, rd_valid, ram_wren;
  logic [3:0] rd_data, ram_data, ram_q;
  logic [3:0] count;
  logic [3:0] ram_wraddress, ram_rdaddress;

  int errors = 0;
  int checks = 0;

  logic [3:0] model_q[$];
  logic [3:0] exp_q[$];
  int         mwp = 0;
  int         mrp = 0;

  ram_fifo_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .wr_req        (wr_req),
    .wr_data       (wr_data),
    .full          (full),
    .rd_req        (rd_req),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .empty         (empty),
    .count         (count),
    .ram_data      (ram_data),
    .ram_wraddress (ram_wraddress),
    .ram_rdaddress (ram_rdaddress),
    .ram_wren      (ram_wren),
    .ram_q         (ram_q)
  );

  always #5 clock = ~clock;

  // Stand-in for the external 4x16 dual-port RAM with a registered read port.
  logic [3:0] mem [16];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_wraddress] <= ram_data;
    ram_q <= mem[ram_rdaddress];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding read, one cycle after accept.
  always @(negedge clock) begin
    if (!reset) begin
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_valid_unexpected: got rd_valid=1 data=%0h expected no pulse at %0t", rd_data, $time);
        end else begin
          check("rd_data", int'(rd_data), int'(exp_q.pop_front()));
        end
      end else if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL rd_valid_missing: got rd_valid=0 expected data %0h at %0t", exp_q[0], $time);
        void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus, called at a falling edge; checks strobes, advances the model, checks flags.
  task automatic cycle(input logic w, input logic [3:0] d, input logic r, input logic f);
    bit wa, ra;
    wr_req = w; wr_data = d; rd_req = r; flush = f;
    #1;
    wa = w && !f && (model_q.size() < 8);
    ra = r && !f && (model_q.size() > 0);
    check("ram_wren", int'(ram_wren), int'(wa));
    if (wa) check("ram_wraddress", int'(ram_wraddress), mwp);
    if (ra) check("ram_rdaddress", int'(ram_rdaddress), mrp);
    @(posedge clock);
    if (f) begin
      model_q.delete();
      mwp = 0;
      mrp = 0;
    end else begin
      if (ra) begin
        exp_q.push_back(model_q.pop_front());
        mrp = (mrp + 1) % 8;
      end
      if (wa) begin
        model_q.push_back(d);
        mwp = (mwp + 1) % 8;
      end
    end
    @(negedge clock);
    check("count", int'(count), model_q.size());
    check("full", int'(full), int'(model_q.size() == 8));
    check("empty", int'(empty), int'(model_q.size() == 0));
  endtask

  initial begin
    // Reset state, with a write request held to show the write strobe stays low.
    wr_req = 1'b1;
    #2;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_ram_wren", int'(ram_wren), 0);
    wr_req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Fill with 1..8, then a ninth write against full.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b0);
    cycle(1'b1, 4'hE, 1'b0, 1'b0);

    // Drain all eight in back-to-back reads.
    for (int i = 0; i < 8; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    // Wrap: 5 in, 5 out, then 6 more crossing address 7->0.
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 2), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'(4'hA + i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    // Simultaneous read+write at count 3, at full, and at empty.
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 3), 1'b0, 1'b0);
    cycle(1'b1, 4'h7, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 8), 1'b0, 1'b0);
    cycle(1'b1, 4'hD, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b1, 4'h6, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    // Flush at count 5 right after an accepted read; that read's data still arrives.
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i + 1), 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b1, 4'hF, 1'b1, 1'b1);
    check("flush_wraddress", int'(ram_wraddress), 0);
    check("flush_rdaddress", int'(ram_rdaddress), 0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    // Reset mid-burst at count 4 with a rd_valid pulse live: clears without a clock edge.
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i + 4), 1'b0, 1'b0);
    wr_req = 1'b0; rd_req = 1'b1;
    @(posedge clock);
    exp_q.push_back(model_q.pop_front());
    mrp = (mrp + 1) % 8;
    #2;
    check("pre_rst_rd_valid", int'(rd_valid), 1);
    check("pre_rst_count", int'(count), 4);
    wr_req = 1'b1;
    reset = 1'b1;
    #1;
    check("async_rst_count", int'(count), 0);
    check("async_rst_empty", int'(empty), 1);
    check("async_rst_rd_valid", int'(rd_valid), 0);
    check("async_rst_ram_wren", int'(ram_wren), 0);
    check("async_rst_rdaddress", int'(ram_rdaddress), 0);
    exp_q.delete();
    model_q.delete();
    mwp = 0;
    mrp = 0;
    @(negedge clock);
    wr_req = 1'b0; rd_req = 1'b0;
    reset = 1'b0;
    cycle(1'b1, 4'h9, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), 4'($urandom), 1'($urandom_range(0, 99) < 45),
            1'($urandom_range(0, 99) < 3));
    end

    // Drain whatever is left and confirm no reads are outstanding.
    for (int i = 0; i < 10; i++) cycle(1'b0, 4'h0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0);
    check("outstanding_reads", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
